// File: rtl/ex_redirect_ctrl.sv
// Execute-stage sequencing: registers the execute slot, issues fetch redirects and squashes wrong-path beats.
// Optional EX_REDIR_STATS_EN adds saturating redirect/squash event counters.
module ex_redirect_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [15:0] id_pc,
  input  logic        id_is_br,
  input  logic        id_is_jmp,
  input  logic        br_taken,
  input  logic [15:0] tgt_pc,
  input  logic        wb_ready,
  output logic        ex_valid,
  output logic [15:0] ex_pc,
  output logic        redir_valid,
  output logic [15:0] redir_pc,
`ifdef EX_REDIR_STATS_EN
  output logic [15:0] stat_redir,
  output logic [15:0] stat_squash,
`endif
  input  logic        redir_ack
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REDIR  = 2'd1,
    SQUASH = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ex_valid_q, ex_valid_d;
  logic [15:0] ex_pc_q, ex_pc_d;
  logic        redir_valid_q, redir_valid_d;
  logic [15:0] redir_pc_q, redir_pc_d;

  logic        id_ready_s;
  logic        accept_s;
  logic        xfer_s;
  logic        run_load_s;

  // Outside RUN every offered beat is swallowed, so decode is never stalled there.
  assign id_ready_s = (state_q != RUN) || !ex_valid_q || wb_ready;
  assign accept_s   = id_valid && id_ready_s;
  assign xfer_s     = id_is_jmp || (id_is_br && br_taken);
  assign run_load_s = (state_q == RUN) && accept_s;

  assign id_ready    = id_ready_s;
  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;

  // Next-state, slot and redirect logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;

    if (run_load_s) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = id_pc;
    end else if (wb_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end

    case (state_q)
      RUN: begin
        // The transfer beat still enters the slot; only later beats are wrong-path.
        if (run_load_s && xfer_s) begin
          redir_pc_d    = tgt_pc;
          redir_valid_d = 1'b1;
          state_d       = REDIR;
        end else begin
          state_d = RUN;
        end
      end
      REDIR: begin
        if (redir_ack) begin
          redir_valid_d = 1'b0;
          if (FLUSH_INIT == 3'd0) begin
            state_d = RUN;
          end else begin
            cnt_d   = FLUSH_INIT;
            state_d = SQUASH;
          end
        end else begin
          state_d = REDIR;
        end
      end
      SQUASH: begin
        if (accept_s) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end else begin
            state_d = SQUASH;
          end
        end else begin
          state_d = SQUASH;
        end
      end
      default: begin
        state_d       = RUN;
        cnt_d         = 3'd0;
        redir_valid_d = 1'b0;
      end
    endcase
  end

  // State, slot and redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 16'h0000;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

`ifdef EX_REDIR_STATS_EN
  logic [15:0] stat_redir_q, stat_squash_q;
  logic        ack_hs_s;
  logic        drop_s;

  assign ack_hs_s    = (state_q == REDIR) && redir_ack;
  assign drop_s      = accept_s && (state_q != RUN);
  assign stat_redir  = stat_redir_q;
  assign stat_squash = stat_squash_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_redir_q  <= 16'h0000;
      stat_squash_q <= 16'h0000;
    end else begin
      if (ack_hs_s && (stat_redir_q != 16'hFFFF)) begin
        stat_redir_q <= stat_redir_q + 16'h0001;
      end
      if (drop_s && (stat_squash_q != 16'hFFFF)) begin
        stat_squash_q <= stat_squash_q + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Bench for ex_redirect_ctrl: directed plan steps then random traffic against a behavioural model.
module tb_ex_redirect_ctrl;
  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [15:0] id_pc = 16'h0;
  logic        id_is_br = 1'b0;
  logic        id_is_jmp = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] tgt_pc = 16'h0;
  logic        wb_ready = 1'b0;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        redir_ack = 1'b0;
`ifdef EX_REDIR_STATS_EN
  logic [15:0] stat_redir, stat_squash;
`endif

  int comp_cnt = 0;
  int err_cnt  = 0;

  // Model: pending redirect, wrong-path beats still to drop, slot contents, event tallies.
  bit          m_pend;
  int          m_drop;
  bit          m_exv;
  logic [15:0] m_expc;
  logic [15:0] m_rpc;
  int          m_rd;
  int          m_sq;

  ex_redirect_ctrl #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_is_br(id_is_br), .id_is_jmp(id_is_jmp), .br_taken(br_taken), .tgt_pc(tgt_pc),
    .wb_ready(wb_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
`ifdef EX_REDIR_STATS_EN
    .stat_redir(stat_redir), .stat_squash(stat_squash),
`endif
    .redir_ack(redir_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    comp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_drop = 0; m_exv = 1'b0; m_expc = 16'h0; m_rpc = 16'h0;
    m_rd = 0; m_sq = 0;
  endtask

  task automatic chk_outputs();
    chk("ex_valid", {15'd0, ex_valid}, {15'd0, m_exv});
    chk("ex_pc", ex_pc, m_expc);
    chk("redir_valid", {15'd0, redir_valid}, {15'd0, m_pend});
    chk("redir_pc", redir_pc, m_rpc);
`ifdef EX_REDIR_STATS_EN
    chk("stat_redir", stat_redir, 16'(m_rd));
    chk("stat_squash", stat_squash, 16'(m_sq));
`endif
  endtask

  // One clock: drive, check the handshake, advance the model, check registered outputs.
  task automatic cyc(input logic v, input logic [15:0] pc, input logic br, input logic jmp,
                     input logic tk, input logic [15:0] tgt, input logic wb, input logic ack);
    logic        exp_rdy, acc, run;
    bit          n_pend, n_exv;
    int          n_drop, n_rd, n_sq;
    logic [15:0] n_expc, n_rpc;
    id_valid = v; id_pc = pc; id_is_br = br; id_is_jmp = jmp; br_taken = tk;
    tgt_pc = tgt; wb_ready = wb; redir_ack = ack;
    #1;
    run     = !m_pend && (m_drop == 0);
    exp_rdy = !run || !m_exv || wb;
    chk("id_ready", {15'd0, id_ready}, {15'd0, exp_rdy});
    acc = v && exp_rdy;
    n_pend = m_pend; n_drop = m_drop; n_exv = m_exv; n_expc = m_expc; n_rpc = m_rpc;
    n_rd = m_rd; n_sq = m_sq;
    if (m_pend) begin
      if (acc) n_sq = n_sq + 1;
      if (ack) begin
        n_pend = 1'b0; n_drop = FD; n_rd = n_rd + 1;
      end
    end else if (m_drop > 0) begin
      if (acc) begin
        n_drop = n_drop - 1; n_sq = n_sq + 1;
      end
    end else if (acc) begin
      n_exv = 1'b1; n_expc = pc;
      if (jmp || (br && tk)) begin
        n_pend = 1'b1; n_rpc = tgt;
      end
    end
    if (!(run && acc) && wb) n_exv = 1'b0;
    if (n_rd > 65535) n_rd = 65535;
    if (n_sq > 65535) n_sq = 65535;
    @(posedge clk);
    #1;
    m_pend = n_pend; m_drop = n_drop; m_exv = n_exv; m_expc = n_expc; m_rpc = n_rpc;
    m_rd = n_rd; m_sq = n_sq;
    chk_outputs();
  endtask

  task automatic beat(input logic [15:0] pc);
    cyc(1'b1, pc, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic v, br, jmp, tk, wb, ack;
    model_reset();
    #1;
    chk_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Straight-line beats
    beat(16'h0000); beat(16'h0002); beat(16'h0004); beat(16'h0006);

    // Taken branch, ack held off three cycles, ack together with a beat, two more drops
    cyc(1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
    beat(16'h0012); beat(16'h0014); beat(16'h0016);
    cyc(1'b1, 16'h0018, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 16'h001A, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b1, 1'b0);
    cyc(1'b1, 16'h001C, 1'b1, 1'b0, 1'b1, 16'h0300, 1'b1, 1'b0);
    beat(16'h0040);

    // Not-taken branch
    cyc(1'b1, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b0);
    beat(16'h0044);

    // Backpressure with a full slot
    beat(16'h0002);
    cyc(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    beat(16'h0004);

    // Redirect while the slot is stalled, ack outside REDIR ignored
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 16'h0050, 1'b0, 1'b1, 1'b0, 16'h0090, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    beat(16'h0052);

    // Reset in SQUASH with one beat left to drop
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(16'h0100);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 3) == 0);
      jmp = ($urandom_range(0, 7) == 0);
      tk  = $urandom_range(0, 1);
      wb  = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) == 0);
      cyc(v, 16'($urandom) & 16'hFFFE, br, jmp, tk, 16'($urandom) & 16'hFFFE, wb, ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/ex_redirect_ctrl.md
Name: ex_redirect_ctrl

Overview:
Sequencing controller between decode and the execute stage. It registers the instruction slot handed to execute and owns control-transfer redirects. Branches and jumps resolved in execute cause it to issue a redirect PC to fetch with a valid/ack handshake. It then squashes wrong-path beats until fetch is back on the correct path.

Parameters:
FLUSH_DEPTH, 2, wrong-path beats still in flight after fetch accepts a redirect; these are dropped (0 to 7).

Ports:
clk  in  1  clock
rst_n  in  1  reset
id_valid  in  1  decode offers a beat
id_ready  out  1  controller accepts the beat
id_pc  in  16  PC of the offered beat
id_is_br  in  1  beat is a conditional branch
id_is_jmp  in  1  beat is an unconditional or register jump
br_taken  in  1  resolved branch condition for the offered beat, same cycle
tgt_pc  in  16  resolved target for the offered beat, same cycle
wb_ready  in  1  downstream accepts the execute slot
ex_valid  out  1  execute slot holds a live beat
ex_pc  out  16  PC of the live beat
redir_valid  out  1  redirect request to fetch
redir_pc  out  16  redirect target
redir_ack  in  1  fetch accepts the redirect

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs are 0, state is RUN, squash counter is 0. Reset mid-redirect or mid-squash abandons the sequence without a pulse.
- Acceptance: id_ready = !ex_valid || wb_ready. id_ready is ORed high in REDIR and SQUASH, where beats are dropped and never reach the slot.
- Accept = id_valid && id_ready.
- Slot register: ex_valid and ex_pc load on a RUN-state accept.
- Slot clear: ex_valid clears when wb_ready is high and there is no new load. Load latency is 1 cycle.
- Control transfer: xfer = id_is_jmp || (id_is_br && br_taken), evaluated on a RUN accept. The transfer beat itself enters the slot, because the link write needs it.
- State RUN: an accept with xfer registers tgt_pc into redir_pc and moves to REDIR. redir_valid rises the next cycle.
- State REDIR: redir_valid = 1 and redir_pc stays stable until redir_ack.
  - Every accept in REDIR is dropped and is not counted.
  - On redir_ack, load the counter with FLUSH_DEPTH and go to SQUASH. If FLUSH_DEPTH = 0, go straight to RUN.
  - redir_ack together with id_valid in the same cycle: the beat is dropped and the counter is loaded, not decremented.
- State SQUASH: each accept is dropped and decrements the counter. id_is_br, id_is_jmp and br_taken are ignored.
  - When a decrement reaches 0, go to RUN. The next beat is accepted normally.
  - With no accept, the counter holds.
- Redirect while slot stalled: REDIR entry does not depend on wb_ready. The stalled slot beat stays held and is independent of the redirect.
- redir_ack outside REDIR is ignored.
- Widths: the counter is 3 bits. PCs pass through unmodified, with no arithmetic.

Optional Feature:
EX_REDIR_STATS_EN
- Defined: adds outputs stat_redir[15:0] and stat_squash[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - stat_redir increments on each redir_ack handshake.
  - stat_squash increments on each dropped beat, in REDIR or SQUASH.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Straight line: 4 beats, PC 0x0000/0x0002/0x0004/0x0006, no xfer, wb_ready = 1 → ex_pc follows 1 cycle later. No redir_valid.
- Taken branch: beat PC 0x0010 with id_is_br = 1, br_taken = 1, tgt_pc 0x0040 → ex_pc 0x0010 next cycle and redir_valid = 1, redir_pc 0x0040. Hold redir_ack low 3 cycles while offering 3 beats → all dropped, redir_pc stable. Ack → next 2 beats dropped, then the beat at 0x0040 reaches the slot.
- Not-taken branch: id_is_br = 1, br_taken = 0, tgt_pc 0x0080 → no redirect, the next beat passes.
- Backpressure: wb_ready = 0 with the slot full → id_ready = 0, and ex_pc holds 0x0002 until wb_ready rises.
- Simultaneous events: redir_ack and id_valid in the same cycle with FLUSH_DEPTH = 2 → exactly 2 further beats dropped, counted by stat_squash when EX_REDIR_STATS_EN is defined.
- Reset mid-sequence: assert rst_n = 0 during SQUASH with counter 1 → all outputs 0 immediately. After release, the first beat passes.
